// File: rtl/regpair_file_p_pkg.sv
// Shared types for the register-pair file: op codes, FSM states, pair indices, step encoding.
package regpair_file_p_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_RD_LO = 3'd1,
    OP_RD_HI = 3'd2,
    OP_WR_LO = 3'd3,
    OP_WR_HI = 3'd4,
    OP_ADR   = 3'd5,
    OP_INC   = 3'd6,
    OP_DEC   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UPD  = 2'd1,
    XCH2 = 2'd2
  } state_e;

  localparam int PAIR_BC = 0;
  localparam int PAIR_DE = 1;
  localparam int PAIR_HL = 2;
  localparam int PAIR_WZ = 3;
  localparam int PAIR_PC = 4;
  localparam int PAIR_SP = 5;

  localparam logic STEP_1 = 1'b0;
  localparam logic STEP_2 = 1'b1;

endpackage

// File: rtl/regpair_file_p_if.sv
// Op request / data / address bundle between the control sequencer (master) and the pair file (slave).
interface regpair_file_p_if import regpair_file_p_pkg::*; #(
  parameter int DW    = 8,
  parameter int NPAIR = 6
);
  localparam int AW = 2 * DW;
  localparam int SW = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  logic          op_valid;
  logic          op_ready;
  op_e           op_code;
  logic [SW-1:0] sel;
  logic [SW-1:0] sel_b;
  logic          step;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          data_oe;
  logic [AW-1:0] address;
  logic          carry_out;
  logic          zero_out;

  modport master (
    output op_valid, op_code, sel, sel_b, step, data_in,
    input  op_ready, data_out, data_oe, address, carry_out, zero_out
  );

  modport slave (
    input  op_valid, op_code, sel, sel_b, step, data_in,
    output op_ready, data_out, data_oe, address, carry_out, zero_out
  );

endinterface

// File: rtl/regpair_file_p_addr_incdec.sv
// Combinational AW-bit +/-1 or +/-2 unit; carry is bit AW of the extended result (borrow on dec).
// Zero latency, no handshake.
module regpair_file_p_addr_incdec #(
  parameter int AW = 16
) (
  input  logic [AW-1:0] val,
  input  logic          dec,
  input  logic          step,
  output logic [AW-1:0] result,
  output logic          carry,
  output logic          zero
);

  logic [AW:0] delta;
  logic [AW:0] sum;

  always_comb begin
    delta = step ? (AW+1)'(2) : (AW+1)'(1);
    sum   = dec ? ({1'b0, val} - delta) : ({1'b0, val} + delta);
  end

  assign result = sum[AW-1:0];
  assign carry  = sum[AW];
  assign zero   = (sum[AW-1:0] == '0);

endmodule

// File: rtl/regpair_file_p.sv
// NPAIR x 2*DW register-pair file: byte rd/wr, address latch, inc/dec write-back, pair exchange.
// Single-cycle ops except INC/DEC and XCHG (2 cycles, op_ready low in the second).
module regpair_file_p import regpair_file_p_pkg::*; #(
  parameter int               DW     = 8,
  parameter int               NPAIR  = 6,
  parameter int               PC_IDX = 4,
  parameter logic [2*DW-1:0]  PC_RST = 'h0100
) (
  input  logic             phi1,
  input  logic             rst,
  regpair_file_p_if.slave  bus
);

  localparam int AW = 2 * DW;
  localparam int SW = (NPAIR > 1) ? $clog2(NPAIR) : 1;

  logic [AW-1:0] pair_q [NPAIR];
  state_e        state_q, state_d;
  logic          op_ready_c;
  logic          accept;
  logic          sel_ok, sel_b_ok, op_ok;
  logic [AW-1:0] sel_pair, sel_b_pair;
  logic [AW-1:0] tmp_q;
  logic [SW-1:0] cur_sel_q;
  logic          cur_dec_q, cur_step_q;
  logic [DW-1:0] data_out_q;
  logic          data_oe_q;
  logic [AW-1:0] address_q;
  logic          carry_q, zero_q;
  logic [AW-1:0] incdec_res;
  logic          incdec_c, incdec_z;

  // Out-of-range selects turn the accepted op into a no-op.
  assign sel_ok     = int'(bus.sel) < NPAIR;
  assign sel_b_ok   = int'(bus.sel_b) < NPAIR;
  assign op_ok      = sel_ok && sel_b_ok;
  assign sel_pair   = sel_ok   ? pair_q[bus.sel]   : '0;
  assign sel_b_pair = sel_b_ok ? pair_q[bus.sel_b] : '0;
  assign accept     = bus.op_valid && op_ready_c;

  regpair_file_p_addr_incdec #(.AW(AW)) u_incdec (
    .val    (pair_q[cur_sel_q]),
    .dec    (cur_dec_q),
    .step   (cur_step_q),
    .result (incdec_res),
    .carry  (incdec_c),
    .zero   (incdec_z)
  );

  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    op_ready_c = 1'b0;
    case (state_q)
      IDLE: begin
        op_ready_c = 1'b1;
        if (bus.op_valid && op_ok) begin
          if (bus.op_code == OP_INC || bus.op_code == OP_DEC) state_d = UPD;
          else if (bus.op_code == OP_NOP && bus.step)         state_d = XCH2;
        end
      end
      UPD:     state_d = IDLE;
      XCH2:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge phi1 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NPAIR; i++) pair_q[i] <= (i == PC_IDX) ? PC_RST : '0;
      tmp_q      <= '0;
      cur_sel_q  <= '0;
      cur_dec_q  <= 1'b0;
      cur_step_q <= 1'b0;
      data_out_q <= '0;
      data_oe_q  <= 1'b0;
      address_q  <= PC_RST;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      data_oe_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && op_ok) begin
            case (bus.op_code)
              OP_RD_LO: begin data_out_q <= sel_pair[DW-1:0];  data_oe_q <= 1'b1; end
              OP_RD_HI: begin data_out_q <= sel_pair[AW-1:DW]; data_oe_q <= 1'b1; end
              OP_WR_LO: pair_q[bus.sel][DW-1:0]  <= bus.data_in;
              OP_WR_HI: pair_q[bus.sel][AW-1:DW] <= bus.data_in;
              OP_ADR:   address_q <= sel_pair;
              OP_INC, OP_DEC: begin
                address_q  <= sel_pair;
                cur_sel_q  <= bus.sel;
                cur_dec_q  <= (bus.op_code == OP_DEC);
                cur_step_q <= bus.step;
              end
              OP_NOP: begin
                // step=1 on NOP encodes XCHG; sel_b is remembered for the second half.
                if (bus.step) begin
                  tmp_q           <= sel_pair;
                  pair_q[bus.sel] <= sel_b_pair;
                  cur_sel_q       <= bus.sel_b;
                end
              end
              default: ;
            endcase
          end
        end
        UPD: begin
          pair_q[cur_sel_q] <= incdec_res;
          carry_q           <= incdec_c;
          zero_q            <= incdec_z;
        end
        XCH2:    pair_q[cur_sel_q] <= tmp_q;
        default: ;
      endcase
    end
  end

  assign bus.op_ready  = op_ready_c;
  assign bus.data_out  = data_out_q;
  assign bus.data_oe   = data_oe_q;
  assign bus.address   = address_q;
  assign bus.carry_out = carry_q;
  assign bus.zero_out  = zero_q;

endmodule

// File: tb/tb_regpair_file_p.sv
// Directed bench for regpair_file_p: reset, byte rd/wr, inc/dec table, exchange, reset mid-op.
module tb_regpair_file_p;
  import regpair_file_p_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regpair_file_p_if #(.DW(8), .NPAIR(6)) bus ();

  regpair_file_p #(.DW(8), .NPAIR(6), .PC_IDX(4), .PC_RST(16'h0100)) dut (
    .phi1 (clk),
    .rst  (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] init;
    logic        dec;
    logic        step;
    logic [15:0] exp_res;
    logic        exp_c;
    logic        exp_z;
  } vec_t;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive at negedge, accepted at the following posedge, outputs sampled 1 time unit later.
  task automatic issue(input op_e op, input logic [2:0] s, input logic [2:0] sb,
                       input logic st, input logic [7:0] d);
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op_code  = op;
    bus.sel      = s;
    bus.sel_b    = sb;
    bus.step     = st;
    bus.data_in  = d;
    @(posedge clk);
    #1;
    bus.op_valid = 1'b0;
    bus.op_code  = OP_NOP;
    bus.step     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pair(input logic [2:0] s, input logic [15:0] v);
    issue(OP_WR_LO, s, 3'd0, 1'b0, v[7:0]);
    issue(OP_WR_HI, s, 3'd0, 1'b0, v[15:8]);
  endtask

  task automatic read_pair(input logic [2:0] s, output logic [15:0] v);
    issue(OP_ADR, s, 3'd0, 1'b0, 8'h00);
    v = bus.address;
  endtask

  vec_t        vecs [7];
  logic [15:0] rd;
  logic [15:0] addr_before;

  initial begin
    checks   = 0;
    failures = 0;
    bus.op_valid = 1'b0;
    bus.op_code  = OP_NOP;
    bus.sel      = '0;
    bus.sel_b    = '0;
    bus.step     = 1'b0;
    bus.data_in  = '0;

    vecs[0] = '{sel:3'd4, init:16'h0100, dec:1'b0, step:1'b0, exp_res:16'h0101, exp_c:1'b0, exp_z:1'b0};
    vecs[1] = '{sel:3'd2, init:16'hFFFF, dec:1'b0, step:1'b0, exp_res:16'h0000, exp_c:1'b1, exp_z:1'b1};
    vecs[2] = '{sel:3'd5, init:16'h0001, dec:1'b1, step:1'b1, exp_res:16'hFFFF, exp_c:1'b1, exp_z:1'b0};
    vecs[3] = '{sel:3'd3, init:16'hFFFE, dec:1'b0, step:1'b1, exp_res:16'h0000, exp_c:1'b1, exp_z:1'b1};
    vecs[4] = '{sel:3'd0, init:16'h0000, dec:1'b1, step:1'b0, exp_res:16'hFFFF, exp_c:1'b1, exp_z:1'b0};
    vecs[5] = '{sel:3'd1, init:16'h1234, dec:1'b1, step:1'b1, exp_res:16'h1232, exp_c:1'b0, exp_z:1'b0};
    vecs[6] = '{sel:3'd2, init:16'h0001, dec:1'b1, step:1'b0, exp_res:16'h0000, exp_c:1'b0, exp_z:1'b1};

    // Reset values while rst is held.
    rst = 1'b1;
    #3;
    check("rst_address",  bus.address, 16'h0100);
    check("rst_op_ready", 16'(bus.op_ready), 16'h1);
    check("rst_data_oe",  16'(bus.data_oe), 16'h0);
    check("rst_data_out", 16'(bus.data_out), 16'h00);
    check("rst_carry",    16'(bus.carry_out), 16'h0);
    check("rst_zero",     16'(bus.zero_out), 16'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // INC of PC straight out of reset.
    issue(OP_INC, 3'd4, 3'd0, STEP_1, 8'h00);
    check("inc_pc_addr",  bus.address, 16'h0100);
    check("inc_pc_busy",  16'(bus.op_ready), 16'h0);
    tick();
    check("inc_pc_ready", 16'(bus.op_ready), 16'h1);
    check("inc_pc_c",     16'(bus.carry_out), 16'h0);
    check("inc_pc_z",     16'(bus.zero_out), 16'h0);
    read_pair(3'd4, rd);
    check("inc_pc_val",   rd, 16'h0101);

    // Byte write / read on BC.
    issue(OP_WR_LO, 3'd0, 3'd0, 1'b0, 8'h38);
    issue(OP_WR_HI, 3'd0, 3'd0, 1'b0, 8'h57);
    check("wr_no_oe",     16'(bus.data_oe), 16'h0);
    issue(OP_RD_HI, 3'd0, 3'd0, 1'b0, 8'h00);
    check("rd_hi_data",   16'(bus.data_out), 16'h57);
    check("rd_hi_oe",     16'(bus.data_oe), 16'h1);
    tick();
    check("rd_hi_oe_off", 16'(bus.data_oe), 16'h0);
    issue(OP_RD_LO, 3'd0, 3'd0, 1'b0, 8'h00);
    check("rd_lo_data",   16'(bus.data_out), 16'h38);
    check("rd_lo_oe",     16'(bus.data_oe), 16'h1);

    // INC/DEC table: preload, operate, check address/flags/result.
    for (int i = 0; i < 7; i++) begin
      write_pair(vecs[i].sel, vecs[i].init);
      issue(vecs[i].dec ? OP_DEC : OP_INC, vecs[i].sel, 3'd0, vecs[i].step, 8'h00);
      check($sformatf("vec%0d_addr", i), bus.address, vecs[i].init);
      check($sformatf("vec%0d_busy", i), 16'(bus.op_ready), 16'h0);
      tick();
      check($sformatf("vec%0d_c", i), 16'(bus.carry_out), 16'(vecs[i].exp_c));
      check($sformatf("vec%0d_z", i), 16'(bus.zero_out),  16'(vecs[i].exp_z));
      read_pair(vecs[i].sel, rd);
      check($sformatf("vec%0d_res", i), rd, vecs[i].exp_res);
    end
    // Flags hold across non-INC/DEC ops (last vector left c=0 z=1).
    write_pair(3'd3, 16'hABCD);
    check("flag_hold_c", 16'(bus.carry_out), 16'h0);
    check("flag_hold_z", 16'(bus.zero_out), 16'h1);

    // XCHG DE <-> HL, then self-exchange.
    write_pair(3'd1, 16'h00AA);
    write_pair(3'd2, 16'h1234);
    issue(OP_NOP, 3'd1, 3'd2, 1'b1, 8'h00);
    check("xchg_busy",  16'(bus.op_ready), 16'h0);
    tick();
    check("xchg_ready", 16'(bus.op_ready), 16'h1);
    read_pair(3'd1, rd);
    check("xchg_de", rd, 16'h1234);
    read_pair(3'd2, rd);
    check("xchg_hl", rd, 16'h00AA);
    issue(OP_NOP, 3'd1, 3'd1, 1'b1, 8'h00);
    check("xself_busy", 16'(bus.op_ready), 16'h0);
    tick();
    read_pair(3'd1, rd);
    check("xself_de", rd, 16'h1234);
    issue(OP_NOP, 3'd1, 3'd2, 1'b0, 8'h00);
    check("nop_ready", 16'(bus.op_ready), 16'h1);
    read_pair(3'd1, rd);
    check("nop_de", rd, 16'h1234);

    // Out-of-range selects: accepted, nothing changes.
    read_pair(3'd5, addr_before);
    issue(OP_WR_LO, 3'd7, 3'd0, 1'b0, 8'hEE);
    check("oor_wr_ready", 16'(bus.op_ready), 16'h1);
    issue(OP_ADR, 3'd6, 3'd0, 1'b0, 8'h00);
    check("oor_adr", bus.address, addr_before);
    issue(OP_INC, 3'd7, 3'd0, 1'b0, 8'h00);
    check("oor_inc_ready", 16'(bus.op_ready), 16'h1);
    check("oor_inc_addr",  bus.address, addr_before);

    // Asynchronous reset in the middle of an INC update cycle.
    write_pair(3'd4, 16'h2000);
    issue(OP_INC, 3'd4, 3'd0, 1'b0, 8'h00);
    check("mid_busy", 16'(bus.op_ready), 16'h0);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 16'(bus.op_ready), 16'h1);
    check("mid_rst_addr",  bus.address, 16'h0100);
    check("mid_rst_z",     16'(bus.zero_out), 16'h0);
    @(negedge clk);
    rst = 1'b0;
    read_pair(3'd4, rd);
    check("mid_rst_pc", rd, 16'h0100);
    read_pair(3'd0, rd);
    check("mid_rst_bc", rd, 16'h0000);
    read_pair(3'd2, rd);
    check("mid_rst_hl", rd, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
